display_scan_mux: RTL and testbench

//  Time-multiplexed scanner for the N-digit common-anode 7-segment display.

---
 rtl/display_scan_mux_if.sv | 25 ++
 rtl/display_scan_mux.sv | 95 +++++++++
 tb/tb_display_scan_mux.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/display_scan_mux_if.sv
// Bundle between the value source, the scan multiplexer and the segment decoder/board pins.
interface display_scan_if #(
   parameter int unsigned N_DIGITS = 4
) ();
   localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   logic [4*N_DIGITS-1:0] data_in;
   logic                  load;
   logic                  blank_lz;
   logic [3:0]            nibble;
   logic                  seg_blank;
   logic [N_DIGITS-1:0]   an_n;
   logic [IdxW-1:0]       digit_idx;
   logic                  frame_done;

   modport master (
      output data_in, load, blank_lz,
      input  nibble, seg_blank, an_n, digit_idx, frame_done
   );

   modport slave (
      input  data_in, load, blank_lz,
      output nibble, seg_blank, an_n, digit_idx, frame_done
   );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed scanner for an N-digit common-anode 7-segment display with
// dead-time anti-ghosting and leading-zero blanking. All outputs are registered.
module display_scan_mux #(
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 27000,
   parameter int unsigned DEAD_CYCLES = 16
) (
   input logic          clk,
   input logic          rst_n,
   display_scan_if.slave scan_io
);
   localparam int unsigned IdxW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned DivW  = $clog2(REFRESH_DIV);
   localparam int unsigned DataW = 4 * N_DIGITS;

   localparam logic [DivW-1:0] DivMax  = DivW'(REFRESH_DIV - 1);
   localparam logic [IdxW-1:0] IdxMax  = IdxW'(N_DIGITS - 1);
   localparam logic [DivW:0]   DeadLim = (DivW + 1)'(DEAD_CYCLES);

   logic [DivW-1:0]     div_q, div_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [DataW-1:0]    shadow_q, shadow_d;
   logic [3:0]          nibble_q, nibble_d;
   logic                seg_blank_q, seg_blank_d;
   logic [N_DIGITS-1:0] an_n_q, an_n_d;
   logic                frame_done_q, frame_done_d;

   logic                wrap;
   logic                dead;
   logic [N_DIGITS-1:0] zero_from;
   logic [N_DIGITS-1:0] blank_vec;

   always_comb begin
      wrap         = (div_q == DivMax);
      div_d        = wrap ? '0 : div_q + 1'b1;
      idx_d        = idx_q;
      frame_done_d = 1'b0;
      if (wrap) begin
         if (idx_q == IdxMax) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
      shadow_d = scan_io.load ? scan_io.data_in : shadow_q;
   end

   // zero_from[i]: shadow digits N-1..i are all zero.
   always_comb begin
      zero_from[N_DIGITS-1] = (shadow_d[DataW-1 -: 4] == 4'h0);
      for (int i = N_DIGITS - 2; i >= 0; i--) begin
         zero_from[i] = zero_from[i+1] && (shadow_d[4*i +: 4] == 4'h0);
      end
      blank_vec    = zero_from & {N_DIGITS{scan_io.blank_lz}};
      blank_vec[0] = 1'b0;
   end

   // Outputs derive from next-state values so they line up with div/idx/shadow.
   always_comb begin
      dead   = ({1'b0, div_d} < DeadLim);
      an_n_d = '1;
      if (!dead) begin
         an_n_d[idx_d] = 1'b0;
      end
      nibble_d    = shadow_d[{idx_d, 2'b00} +: 4];
      seg_blank_d = dead | blank_vec[idx_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         nibble_q     <= '0;
         seg_blank_q  <= 1'b1;
         an_n_q       <= '1;
         frame_done_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         nibble_q     <= nibble_d;
         seg_blank_q  <= seg_blank_d;
         an_n_q       <= an_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign scan_io.nibble     = nibble_q;
   assign scan_io.seg_blank  = seg_blank_q;
   assign scan_io.an_n       = an_n_q;
   assign scan_io.digit_idx  = idx_q;
   assign scan_io.frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: a 4-digit and a 3-digit instance share clock and reset.
module tb_display_scan_mux;
   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   int   k        = 0;

   display_scan_if #(.N_DIGITS(4)) bus4 ();
   display_scan_if #(.N_DIGITS(3)) bus3 ();

   display_scan_mux #(.N_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .scan_io(bus4.slave)
   );

   display_scan_mux #(.N_DIGITS(3), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut3 (
      .clk    (clk),
      .rst_n  (rst_n),
      .scan_io(bus3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] nib2 [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
   logic [3:0] an4  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] nib3 [4] = '{4'h0, 4'h7, 4'h0, 4'h0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         k++;
      end
   endtask

   initial begin
      int d, dv, last, pulses, idx3;
      logic [2:0] an3e;
      rst_n         = 1'b0;
      bus4.data_in  = '0;
      bus4.load     = 1'b0;
      bus4.blank_lz = 1'b0;
      bus3.data_in  = '0;
      bus3.load     = 1'b0;
      bus3.blank_lz = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k     = 0;
      chk("rst_an", bus4.an_n, 4'b1111);
      chk("rst_blank", bus4.seg_blank, 1'b1);
      chk("rst_nib", bus4.nibble, 4'h0);
      chk("rst_idx", bus4.digit_idx, 2'd0);
      chk("rst_fd", bus4.frame_done, 1'b0);

      // Test 1: asynchronous reset in the middle of digit 1's lit window
      tick(12);
      chk("t1_pre_an", bus4.an_n, 4'b1101);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_async_an", bus4.an_n, 4'b1111);
      chk("t1_async_blank", bus4.seg_blank, 1'b1);
      chk("t1_async_idx", bus4.digit_idx, 2'd0);
      chk("t1_async_fd", bus4.frame_done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      k     = 0;
      tick(1);
      chk("t1_dead_an", bus4.an_n, 4'b1111);
      tick(1);
      chk("t1_lit_an", bus4.an_n, 4'b1110);
      chk("t1_lit_blank", bus4.seg_blank, 1'b0);
      chk("t1_lit_nib", bus4.nibble, 4'h0);

      // Test 2: full frame of 16'h1A2F
      bus4.data_in = 16'h1A2F;
      bus4.load    = 1'b1;
      tick(1);
      bus4.load = 1'b0;
      chk("t2_load_nib", bus4.nibble, 4'hF);
      tick(29);
      for (int i = 0; i < 32; i++) begin
         d  = i / 8;
         dv = i % 8;
         chk("t2_nib", bus4.nibble, nib2[d]);
         chk("t2_idx", bus4.digit_idx, d);
         chk("t2_an", bus4.an_n, (dv < 2) ? 4'b1111 : an4[d]);
         chk("t2_blank", bus4.seg_blank, (dv < 2));
         chk("t2_fd", bus4.frame_done, (i == 0));
         tick(1);
      end

      // Test 3: leading-zero blanking
      bus4.data_in  = 16'h0070;
      bus4.load     = 1'b1;
      bus4.blank_lz = 1'b1;
      tick(1);
      bus4.load = 1'b0;
      tick(31);
      for (int i = 0; i < 32; i++) begin
         d  = i / 8;
         dv = i % 8;
         chk("t3_nib", bus4.nibble, nib3[d]);
         chk("t3_blank", bus4.seg_blank, (dv < 2) || (d >= 2));
         tick(1);
      end
      bus4.data_in = 16'h0000;
      bus4.load    = 1'b1;
      tick(1);
      bus4.load = 1'b0;
      tick(31);
      for (int i = 0; i < 32; i++) begin
         d  = i / 8;
         dv = i % 8;
         chk("t3z_nib", bus4.nibble, 4'h0);
         chk("t3z_blank", bus4.seg_blank, (dv < 2) || (d != 0));
         tick(1);
      end
      tick(10);
      chk("t3_lz_on", bus4.seg_blank, 1'b1);
      chk("t3_lz_an", bus4.an_n, 4'b1101);
      bus4.blank_lz = 1'b0;
      tick(1);
      chk("t3_lz_off", bus4.seg_blank, 1'b0);

      // Test 4: load on the edge where digit 1 hands over to digit 2
      tick(4);
      bus4.data_in = 16'h5555;
      bus4.load    = 1'b1;
      tick(1);
      bus4.load = 1'b0;
      chk("t4_nib", bus4.nibble, 4'h5);
      chk("t4_idx", bus4.digit_idx, 2'd2);
      chk("t4_an", bus4.an_n, 4'b1111);
      bus4.data_in = 16'h1234;
      tick(2);
      chk("t4_hold_nib", bus4.nibble, 4'h5);
      chk("t4_hold_an", bus4.an_n, 4'b1011);

      // Tests 5/6: free run 10 frames, also tracking the 3-digit build
      last   = -1;
      pulses = 0;
      for (int i = 0; i < 320; i++) begin
         tick(1);
         if (bus4.frame_done === 1'b1) begin
            pulses++;
            if (last >= 0) chk("t5_period", k - last, 32);
            last = k;
         end
         chk("t5_fd", bus4.frame_done, (k % 32 == 0));
         chk("t5_onehot", ($countones(~bus4.an_n) <= 1), 1'b1);
         idx3 = (k / 8) % 3;
         an3e = (k % 8 < 2) ? 3'b111 : ~(3'b001 << idx3);
         chk("t6_idx", bus3.digit_idx, idx3);
         chk("t6_an", bus3.an_n, an3e);
         chk("t6_fd", bus3.frame_done, (k % 24 == 0));
      end
      chk("t5_pulses", pulses, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
